// File: rtl/riscv_ctrl_pkg.sv
// Shared types and defaults for the RISC_V execution sequencer.
package riscv_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_HALT = 2'd1,
    S_RUN  = 2'd2,
    S_STEP = 2'd3
  } exec_state_t;

  localparam int unsigned RST_HOLD_DEF = 4;

endpackage

// File: rtl/btn_debounce.sv
// Stable-count filter: the output follows the input only after STABLE_CYCLES
// consecutive samples that differ from the current output.
module btn_debounce #(
  parameter int unsigned STABLE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_din,
  output logic o_dout
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_dout <= 1'b0;
    end else if (i_din == r_dout) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
      r_dout <= i_din;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/riscv_exec_ctrl.sv
// Execution sequencer: core clock enable / core reset for halt, step, slow and fast run.
// Define RISCV_EXEC_DEBOUNCE_EN to filter btn_step through btn_debounce.
module riscv_exec_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned RUN_DIV         = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned RST_HOLD        = RST_HOLD_DEF,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_step,
  input  logic             sw_run,
  input  logic             sw_fast,
  input  logic             halt_req,
  output logic             core_en,
  output logic             core_rst_n,
  output logic [CNT_W-1:0] instr_count,
  output logic [1:0]       exec_state
);

  localparam int unsigned DIV_W  = $clog2(RUN_DIV);
  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

  if (RUN_DIV < 2 || RST_HOLD < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_err
    $error("riscv_exec_ctrl: RUN_DIV >= 2, RST_HOLD >= 1, DEBOUNCE_CYCLES >= 1 required");
  end

  exec_state_t       r_state, w_next;
  logic [1:0]        r_step_sync, r_run_sync;
  logic              r_step_prev;
  logic              w_step_lvl, w_step_pulse, w_run;
  logic [DIV_W-1:0]  r_div;
  logic [HOLD_W-1:0] r_hold;
  logic              r_core_en, r_core_rst_n;
  logic              w_core_en_d, w_core_rst_n_d;
  logic [CNT_W-1:0]  r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step_sync <= '0;
      r_run_sync  <= '0;
      r_step_prev <= 1'b0;
    end else begin
      r_step_sync <= {r_step_sync[0], btn_step};
      r_run_sync  <= {r_run_sync[0], sw_run};
      r_step_prev <= w_step_lvl;
    end
  end

`ifdef RISCV_EXEC_DEBOUNCE_EN
  btn_debounce #(
    .STABLE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debounce (
    .clk    (clk),
    .rst_n  (reset),
    .i_din  (r_step_sync[1]),
    .o_dout (w_step_lvl)
  );
`else
  assign w_step_lvl = r_step_sync[1];
`endif

  assign w_step_pulse = w_step_lvl & ~r_step_prev;
  assign w_run        = r_run_sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_RST;
    else        r_state <= w_next;
  end

  // Halt requests beat both run entry and a pending run pulse; steps are allowed under halt_req.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:   if (r_hold == HOLD_W'(RST_HOLD)) w_next = S_HALT;
      S_HALT: begin
        if (w_run && !halt_req) w_next = S_RUN;
        else if (w_step_pulse)  w_next = S_STEP;
      end
      S_RUN:   if (!w_run || halt_req) w_next = S_HALT;
      S_STEP:  w_next = S_HALT;
      default: w_next = S_RST;
    endcase
  end

  always_comb begin
    w_core_en_d    = 1'b0;
    w_core_rst_n_d = (w_next != S_RST);
    case (r_state)
      S_HALT:  w_core_en_d = (w_next == S_STEP);
      S_RUN:   w_core_en_d = (w_next == S_RUN) &&
                             (sw_fast || (r_div == DIV_W'(RUN_DIV - 1)));
      default: w_core_en_d = 1'b0;
    endcase
  end

  // Divider restarts from zero on every entry into S_RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div        <= '0;
      r_hold       <= '0;
      r_core_en    <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_count      <= '0;
    end else begin
      if (r_state == S_RUN && w_next == S_RUN)
        r_div <= (r_div == DIV_W'(RUN_DIV - 1)) ? '0 : r_div + DIV_W'(1);
      else
        r_div <= '0;
      if (r_state == S_RST && r_hold != HOLD_W'(RST_HOLD))
        r_hold <= r_hold + HOLD_W'(1);
      r_core_en    <= w_core_en_d;
      r_core_rst_n <= w_core_rst_n_d;
      if (r_core_en && (r_count != '1))
        r_count <= r_count + CNT_W'(1);
    end
  end

  assign core_en     = r_core_en;
  assign core_rst_n  = r_core_rst_n;
  assign instr_count = r_count;
  assign exec_state  = r_state;

endmodule

// File: tb/tb_riscv_exec_ctrl.sv
// Scoreboard bench for riscv_exec_ctrl: expected core_en pulses (cycle, count) are
// queued as stimulus is applied and matched when core_en is observed high.
module tb_riscv_exec_ctrl;

  localparam int unsigned RUN_DIV  = 8;
  localparam int unsigned RST_HOLD = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned DEB      = 5;
  localparam int          CNT_MAX  = 15;
`ifdef RISCV_EXEC_DEBOUNCE_EN
  localparam int STEP_LAT = 3 + DEB;
`else
  localparam int STEP_LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             btn_step = 1'b0;
  logic             sw_run = 1'b0;
  logic             sw_fast = 1'b0;
  logic             halt_req = 1'b0;
  logic             core_en;
  logic             core_rst_n;
  logic [CNT_W-1:0] instr_count;
  logic [1:0]       exec_state;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;
  exp_t exp_q[$];

  riscv_exec_ctrl #(
    .RUN_DIV         (RUN_DIV),
    .DEBOUNCE_CYCLES (DEB),
    .RST_HOLD        (RST_HOLD),
    .CNT_W           (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_step    (btn_step),
    .sw_run      (sw_run),
    .sw_fast     (sw_fast),
    .halt_req    (halt_req),
    .core_en     (core_en),
    .core_rst_n  (core_rst_n),
    .instr_count (instr_count),
    .exec_state  (exec_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic push_pulse(input int c);
    exp_t e;
    e.cyc = c;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
    if (exp_cnt < CNT_MAX) exp_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (core_en !== 1'b0 || core_rst_n !== 1'b0 || exec_state !== 2'd0 || instr_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: en=%b rst_n=%b st=%0d cnt=%0d, expected 0 0 0 0",
               core_en, core_rst_n, exec_state, instr_count);
    end
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (core_rst_n !== ((k >= 5) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL reset_hold_rst_n: k=%0d got %b expected %b", k, core_rst_n, (k >= 5));
      end
      n_checks++;
      if (exec_state !== ((k >= 5) ? 2'd1 : 2'd0)) begin
        n_fail++;
        $display("FAIL reset_hold_state: k=%0d got %0d expected %0d", k, exec_state, (k >= 5) ? 1 : 0);
      end
      n_checks++;
      if (core_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold_en: k=%0d got %b expected 0", k, core_en);
      end
    end
    n_checks++;
    if (instr_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", instr_count);
    end
  endtask

  task automatic test_step(input string name);
    exp_t e;
    int   c0;
    c0 = cyc;
    btn_step = 1'b1;
    push_pulse(c0 + STEP_LAT);
    for (int k = 1; k <= STEP_LAT + 8; k++) begin
      @(negedge clk);
      if (k == STEP_LAT + 1) btn_step = 1'b0;
      if (core_en === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s: unexpected core_en at cycle %0d", name, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.cnt != int'(instr_count) || exec_state !== 2'd3) begin
            n_fail++;
            $display("FAIL %s: got cycle %0d count %0d state %0d, expected cycle %0d count %0d state 3",
                     name, cyc, instr_count, exec_state, e.cyc, e.cnt);
          end
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing: %0d expected pulses not seen, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (int'(instr_count) != exp_cnt || exec_state !== 2'd1) begin
      n_fail++;
      $display("FAIL %s_after: count %0d state %0d, expected count %0d state 1",
               name, instr_count, exec_state, exp_cnt);
    end
  endtask

  task automatic test_slow_run();
    exp_t e;
    int   c0;
    c0 = cyc;
    sw_fast = 1'b0;
    sw_run  = 1'b1;
    for (int p = 0; p < 5; p++) push_pulse(c0 + 11 + 8 * p);
    for (int k = 1; k <= 62; k++) begin
      @(negedge clk);
      if (k == 20) btn_step = 1'b1;
      if (k == 25) btn_step = 1'b0;
      if (k == 44) sw_run = 1'b0;
      if (k == 40) begin
        n_checks++;
        if (exec_state !== 2'd2) begin
          n_fail++;
          $display("FAIL slow_run_state: got %0d expected 2", exec_state);
        end
      end
      if (core_en === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL slow_run: unexpected core_en at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.cnt != int'(instr_count)) begin
            n_fail++;
            $display("FAIL slow_run: got cycle %0d count %0d, expected cycle %0d count %0d",
                     cyc, instr_count, e.cyc, e.cnt);
          end
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL slow_run_missing: %0d expected pulses not seen, expected 0", exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (int'(instr_count) != exp_cnt || exec_state !== 2'd1) begin
      n_fail++;
      $display("FAIL slow_run_after: count %0d state %0d, expected count %0d state 1",
               instr_count, exec_state, exp_cnt);
    end
  endtask

  task automatic test_halt_req();
    exp_t e;
    int   c0;
    c0 = cyc;
    sw_fast = 1'b1;
    sw_run  = 1'b1;
    for (int k = 4; k <= 6; k++) push_pulse(c0 + k);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 7) begin
        n_checks++;
        if (core_en !== 1'b0 || exec_state !== 2'd1) begin
          n_fail++;
          $display("FAIL halt_req_exit: en=%b state=%0d, expected en=0 state=1", core_en, exec_state);
        end
      end
      if (core_en === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL halt_req: unexpected core_en at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.cnt != int'(instr_count)) begin
            n_fail++;
            $display("FAIL halt_req: got cycle %0d count %0d, expected cycle %0d count %0d",
                     cyc, instr_count, e.cyc, e.cnt);
          end
        end
      end
      if (k == 6) halt_req = 1'b1;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL halt_req_missing: %0d expected pulses not seen, expected 0", exp_q.size());
      exp_q.delete();
    end
    test_step("step_past_bkpt");
    sw_run = 1'b0;
    repeat (3) @(negedge clk);
    halt_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_saturate();
    exp_t e;
    int   c0;
    c0 = cyc;
    sw_fast = 1'b1;
    sw_run  = 1'b1;
    for (int k = 4; k <= 25; k++) push_pulse(c0 + k);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (core_en === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL saturate: unexpected core_en at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.cnt != int'(instr_count)) begin
            n_fail++;
            $display("FAIL saturate: got cycle %0d count %0d, expected cycle %0d count %0d",
                     cyc, instr_count, e.cyc, e.cnt);
          end
        end
      end
      if (k == 23) sw_run = 1'b0;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL saturate_missing: %0d expected pulses not seen, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (instr_count !== 4'd15 || exec_state !== 2'd1) begin
      n_fail++;
      $display("FAIL saturate_hold: count %0d state %0d, expected count 15 state 1", instr_count, exec_state);
    end
  endtask

  task automatic test_reset_midrun();
    sw_fast = 1'b1;
    sw_run  = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (core_en !== 1'b1 || exec_state !== 2'd2) begin
      n_fail++;
      $display("FAIL midrun_running: en=%b state=%0d, expected en=1 state=2", core_en, exec_state);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (core_en !== 1'b0 || core_rst_n !== 1'b0 || instr_count !== 4'd0 || exec_state !== 2'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: en=%b rst_n=%b cnt=%0d st=%0d, expected 0 0 0 0",
               core_en, core_rst_n, instr_count, exec_state);
    end
    exp_cnt = 0;
    sw_run  = 1'b0;
    sw_fast = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 4 || k == 5) begin
        n_checks++;
        if (core_rst_n !== ((k == 5) ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL midrun_rehold: k=%0d got %b expected %b", k, core_rst_n, (k == 5));
        end
      end
    end
    n_checks++;
    if (exec_state !== 2'd1 || core_en !== 1'b0 || instr_count !== 4'd0) begin
      n_fail++;
      $display("FAIL midrun_restart: st=%0d en=%b cnt=%0d, expected 1 0 0", exec_state, core_en, instr_count);
    end
  endtask

`ifdef RISCV_EXEC_DEBOUNCE_EN
  task automatic test_debounce();
    btn_step = 1'b1;
    repeat (3) @(negedge clk);
    btn_step = 1'b0;
    repeat (15) @(negedge clk);
    n_checks++;
    if (int'(instr_count) != exp_cnt) begin
      n_fail++;
      $display("FAIL debounce_glitch: count %0d expected %0d", instr_count, exp_cnt);
    end
    btn_step = 1'b1;
    repeat (8) @(negedge clk);
    btn_step = 1'b0;
    repeat (12) @(negedge clk);
    exp_cnt++;
    n_checks++;
    if (int'(instr_count) != exp_cnt) begin
      n_fail++;
      $display("FAIL debounce_press: count %0d expected %0d", instr_count, exp_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_step("single_step");
    test_slow_run();
    test_halt_req();
    test_saturate();
    test_reset_midrun();
`ifdef RISCV_EXEC_DEBOUNCE_EN
    test_debounce();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
